// File: rtl/int_div_pkg.sv
// rtl/int_div_pkg.sv - shared state, mux-select and message-layout definitions for the iterative divider
package int_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Datapath register update selects for rem/quo/divisor
    typedef enum logic [1:0] {
        DP_HOLD = 2'd0,
        DP_LOAD = 2'd1,
        DP_STEP = 2'd2
    } dp_sel_e;

    function automatic int req_sign_pos(input int nbits);
        return 2 * nbits;
    endfunction

    function automatic int req_dividend_lsb(input int nbits);
        return nbits;
    endfunction

    function automatic int req_divisor_lsb(input int nbits);
        return (nbits > 0) ? 0 : 0;
    endfunction

    function automatic int resp_rem_lsb(input int nbits);
        return nbits;
    endfunction

endpackage

// File: rtl/int_div_iterative_ctrl.sv
// rtl/int_div_iterative_ctrl.sv - divider control FSM: bit counter, val/rdy handshakes, datapath selects
module int_div_iterative_ctrl
    import int_div_pkg::*;
#(
    parameter int nbits = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_val,
    output logic       req_rdy,
    output logic       resp_val,
    input  logic       resp_rdy,
    output logic [1:0] dp_sel,
    output logic       resp_en
);

    localparam int CW = $clog2(nbits) + 1;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_rdy_q, req_rdy_d;
    logic          resp_val_q, resp_val_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dp_sel  = DP_HOLD;
        resp_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_val && req_rdy_q) begin
                    state_d = ST_CALC;
                    cnt_d   = '0;
                    dp_sel  = DP_LOAD;
                end
            end
            ST_CALC: begin
                dp_sel = DP_STEP;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(nbits - 1)) begin
                    state_d = ST_FIX;
                    cnt_d   = '0;
                end
            end
            ST_FIX: begin
                resp_en = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (resp_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Handshake outputs are registered copies of the next-state decode
        req_rdy_d  = (state_d == ST_IDLE);
        resp_val_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            req_rdy_q  <= 1'b1;
            resp_val_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_rdy_q  <= req_rdy_d;
            resp_val_q <= resp_val_d;
        end
    end

    assign req_rdy  = req_rdy_q;
    assign resp_val = resp_val_q;

endmodule

// File: rtl/int_div_iterative.sv
// rtl/int_div_iterative.sv - iterative restoring divider, one quotient bit per cycle, RISC-V div/rem semantics
module int_div_iterative
    import int_div_pkg::*;
#(
    parameter int nbits = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_val,
    output logic             req_rdy,
    input  logic [2*nbits:0] req_msg,
    output logic             resp_val,
    input  logic             resp_rdy,
    output logic [2*nbits-1:0] resp_msg
);

    localparam int SIGN_POS = req_sign_pos(nbits);
    localparam int DVD_LSB  = req_dividend_lsb(nbits);
    localparam int DVS_LSB  = req_divisor_lsb(nbits);
    localparam int REM_LSB  = resp_rem_lsb(nbits);

    logic [1:0]         dp_sel;
    logic               resp_en;

    logic [nbits:0]     rem_q, rem_d;
    logic [nbits-1:0]   quo_q, quo_d;
    logic [nbits-1:0]   dvs_q, dvs_d;
    logic               signed_q, signed_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic [2*nbits-1:0] resp_msg_q, resp_msg_d;

    logic               signed_in, sa_in, sb_in;
    logic [nbits-1:0]   dividend_in, divisor_in;
    logic [nbits+1:0]   rem_shift, diff;
    logic [nbits-1:0]   rem_lo, rem_fix, quo_fix;

    int_div_iterative_ctrl #(.nbits(nbits)) u_ctrl (
        .clk      (clk),
        .reset    (reset),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .resp_val (resp_val),
        .resp_rdy (resp_rdy),
        .dp_sel   (dp_sel),
        .resp_en  (resp_en)
    );

    always_comb begin
        signed_in   = req_msg[SIGN_POS];
        dividend_in = req_msg[DVD_LSB +: nbits];
        divisor_in  = req_msg[DVS_LSB +: nbits];
        sa_in       = signed_in & dividend_in[nbits-1];
        sb_in       = signed_in & divisor_in[nbits-1];

        // rem_q[nbits] is always 0 between steps; the extra top bit of diff is the borrow
        rem_shift = {rem_q, quo_q[nbits-1]};
        diff      = rem_shift - {2'b00, dvs_q};

        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        signed_d = signed_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        case (dp_sel_e'(dp_sel))
            DP_LOAD: begin
                rem_d    = '0;
                quo_d    = sa_in ? -dividend_in : dividend_in;
                dvs_d    = sb_in ? -divisor_in : divisor_in;
                signed_d = signed_in;
                sa_d     = sa_in;
                sb_d     = sb_in;
            end
            DP_STEP: begin
                if (!diff[nbits+1]) begin
                    rem_d = diff[nbits:0];
                    quo_d = {quo_q[nbits-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift[nbits:0];
                    quo_d = {quo_q[nbits-2:0], 1'b0};
                end
            end
            default: ;
        endcase

        // With a zero divisor every trial subtract succeeds, so the remainder path
        // already reproduces the original dividend after the sign fixup.
        rem_lo  = rem_q[nbits-1:0];
        rem_fix = (signed_q && sa_q) ? -rem_lo : rem_lo;
        if (dvs_q == '0) begin
            quo_fix = '1;
        end else if (signed_q && (sa_q ^ sb_q)) begin
            quo_fix = -quo_q;
        end else begin
            quo_fix = quo_q;
        end

        resp_msg_d = resp_msg_q;
        if (resp_en) begin
            resp_msg_d[REM_LSB +: nbits] = rem_fix;
            resp_msg_d[0 +: nbits]       = quo_fix;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            signed_q   <= 1'b0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            resp_msg_q <= '0;
        end else begin
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            signed_q   <= signed_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            resp_msg_q <= resp_msg_d;
        end
    end

    assign resp_msg = resp_msg_q;

endmodule

// File: tb/tb_int_div_iterative.sv
// tb/tb_int_div_iterative.sv - self-checking bench for int_div_iterative against an arithmetic model
module tb_int_div_iterative;

    localparam int NB = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_val = 1'b0;
    logic          req_rdy;
    logic [2*NB:0] req_msg = '0;
    logic          resp_val;
    logic          resp_rdy = 1'b1;
    logic [2*NB-1:0] resp_msg;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int hs_cyc = 0;
    int last_resp_cyc = -100;
    bit seen_first = 1'b0;

    typedef struct {
        logic [63:0] msg;
        int          hs;
    } exp_t;
    exp_t expq[$];

    int_div_iterative #(.nbits(NB)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .req_msg  (req_msg),
        .resp_val (resp_val),
        .resp_rdy (resp_rdy),
        .resp_msg (resp_msg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // {remainder, quotient} from RISC-V division rules
    function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = a;
                r = 32'd0;
            end else begin
                sa = a;
                sb = b;
                q = sa / sb;
                r = sa % sb;
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    always @(negedge clk) begin
        if (!reset && resp_val) begin
            if (expq.size() == 0) begin
                chk("unexpected_resp", {63'd0, resp_val}, 64'd0);
            end else begin
                chk("resp_msg", resp_msg, expq[0].msg);
                chk("req_rdy_while_busy", {63'd0, req_rdy}, 64'd0);
                if (!seen_first) begin
                    chk("latency", 64'(cyc - expq[0].hs), 64'(NB + 2));
                    seen_first = 1'b1;
                end
                if (resp_rdy) begin
                    last_resp_cyc = cyc;
                    void'(expq.pop_front());
                    seen_first = 1'b0;
                end
            end
        end
    end

    task automatic send(input bit s, input logic [31:0] a, input logic [31:0] b, input bit aligned);
        bit ok;
        exp_t e;
        if (!aligned) begin
            @(posedge clk);
            #1;
        end
        req_val = 1'b1;
        req_msg = {s, a, b};
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("req_accept_timeout", 64'd0, 64'd1);
        end else begin
            hs_cyc = cyc;
            e.msg = model(s, a, b);
            e.hs  = cyc;
            expq.push_back(e);
        end
        @(posedge clk);
        #1;
        req_val = 1'b0;
        req_msg = {1'b1, $urandom, $urandom};
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (expq.size() == 0) break;
        end
        if (expq.size() != 0) begin
            chk("resp_timeout", 64'(expq.size()), 64'd0);
            expq.delete();
        end
    endtask

    bit          vs[12] = '{0, 1, 0, 0, 1, 1, 0, 1, 1, 0, 1, 0};
    logic [31:0] va[12] = '{32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'hFFFF_FFFB,
                            32'h8000_0000, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFF9,
                            32'hFFFF_FFFF, 32'h8000_0000, 32'd3};
    logic [31:0] vb[12] = '{32'd7, 32'd2, 32'd2, 32'd0, 32'd0,
                            32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
                            32'h8000_0001, 32'h8000_0000, 32'd10};

    initial begin
        logic [63:0] held;
        bit seen;

        chk("model_100_7", model(0, 32'd100, 32'd7), {32'd2, 32'd14});
        chk("model_s_m7_2", model(1, 32'hFFFF_FFF9, 32'd2), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        chk("model_u_m7_2", model(0, 32'hFFFF_FFF9, 32'd2), {32'd1, 32'h7FFF_FFFC});
        chk("model_5_0", model(0, 32'd5, 32'd0), {32'd5, 32'hFFFF_FFFF});
        chk("model_s_m5_0", model(1, 32'hFFFF_FFFB, 32'd0), {32'hFFFF_FFFB, 32'hFFFF_FFFF});
        chk("model_ovf", model(1, 32'h8000_0000, 32'hFFFF_FFFF), {32'd0, 32'h8000_0000});
        chk("model_u_max_1", model(0, 32'hFFFF_FFFF, 32'd1), {32'd0, 32'hFFFF_FFFF});
        chk("model_9_3", model(0, 32'd9, 32'd3), {32'd0, 32'd3});
        chk("model_s_7_m2", model(1, 32'd7, 32'hFFFF_FFFE), {32'd1, 32'hFFFF_FFFD});

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_rdy", {63'd0, req_rdy}, 64'd1);
        chk("reset_resp_val", {63'd0, resp_val}, 64'd0);
        chk("reset_resp_msg", resp_msg, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            send(vs[i], va[i], vb[i], 1'b0);
            wait_done();
        end

        // Backpressure, then a request waiting on the response handshake
        @(posedge clk);
        #1;
        resp_rdy = 1'b0;
        send(0, 32'd1000, 32'd10, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (resp_val) begin
                seen = 1'b1;
                break;
            end
        end
        chk("bp_resp_seen", {63'd0, seen}, 64'd1);
        held = resp_msg;
        repeat (5) begin
            @(negedge clk);
            chk("bp_resp_val", {63'd0, resp_val}, 64'd1);
            chk("bp_msg_stable", resp_msg, held);
            chk("bp_req_rdy", {63'd0, req_rdy}, 64'd0);
        end
        @(posedge clk);
        #1;
        resp_rdy = 1'b1;
        send(1, 32'hFFFF_FF9C, 32'd7, 1'b1);
        chk("b2b_accept_cycle", 64'(hs_cyc), 64'(last_resp_cyc + 1));
        wait_done();

        // Reset during CALC discards the operation
        send(0, 32'd1000, 32'd3, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        expq.delete();
        seen_first = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midreset_req_rdy", {63'd0, req_rdy}, 64'd1);
        chk("midreset_resp_val", {63'd0, resp_val}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        send(0, 32'd9, 32'd3, 1'b0);
        wait_done();
        repeat (40) begin
            @(negedge clk);
            chk("idle_no_resp", {63'd0, resp_val}, 64'd0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d passed=%0d", checks, passes);
        $fatal(1);
    end

endmodule
